// File: rtl/cond_logic_unit.sv
// cond_logic_unit
// Conditional-execution unit for the ARM-style datapath. Evaluates the 16
// condition codes against the registered NZCV flag file, gates the decoder's
// PC-source / register-write / memory-write requests, updates the N/Z and
// C/V flag groups under separate write enables, and keeps saturating
// executed/skipped instruction counters for debug.
//
// Parameters:
//   PIPE_OUT    0: enables combinational from current cond/flags
//               1: enables registered, visible one cycle after the instruction
//   CNT_W       width of exec_count / skip_count
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   instr_valid  current instruction is real (0 = bubble/stall)
//   cond         instruction condition field [31:28]
//   alu_flags    {N,Z,C,V} produced by the ALU for the current instruction
//   flag_w       [1] write N,Z   [0] write C,V
//   pcs          decoder PC-source request
//   reg_w        decoder register-write request
//   mem_w        decoder memory-write request
//   no_write     suppress register write (compare/test ops)
//   cnt_clr      clear both counters
//   pc_src       gated PC source
//   reg_write    gated register write
//   mem_write    gated memory write
//   cond_ex      condition passed for the current instruction (combinational)
//   flags        registered {N,Z,C,V}
//   exec_count   valid instructions whose condition passed (saturating)
//   skip_count   valid instructions whose condition failed (saturating)

module cond_logic_unit #(
    parameter int unsigned PIPE_OUT = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic             cnt_clr,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_CS = 4'b0010,
        CC_CC = 4'b0011,
        CC_MI = 4'b0100,
        CC_PL = 4'b0101,
        CC_VS = 4'b0110,
        CC_VC = 4'b0111,
        CC_HI = 4'b1000,
        CC_LS = 4'b1001,
        CC_GE = 4'b1010,
        CC_LT = 4'b1011,
        CC_GT = 4'b1100,
        CC_LE = 4'b1101,
        CC_AL = 4'b1110,
        CC_NV = 4'b1111
    } cond_code_e;

    logic [3:0]       flag_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             cond_pass;
    logic             ex;
    logic             pc_src_g;
    logic             reg_write_g;
    logic             mem_write_g;

    assign flag_n = flag_q[3];
    assign flag_z = flag_q[2];
    assign flag_c = flag_q[1];
    assign flag_v = flag_q[0];

    // Condition evaluation against the registered flags only.
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond_code_e'(cond))
            CC_EQ: cond_pass = flag_z;
            CC_NE: cond_pass = ~flag_z;
            CC_CS: cond_pass = flag_c;
            CC_CC: cond_pass = ~flag_c;
            CC_MI: cond_pass = flag_n;
            CC_PL: cond_pass = ~flag_n;
            CC_VS: cond_pass = flag_v;
            CC_VC: cond_pass = ~flag_v;
            CC_HI: cond_pass = flag_c & ~flag_z;
            CC_LS: cond_pass = ~flag_c | flag_z;
            CC_GE: cond_pass = (flag_n == flag_v);
            CC_LT: cond_pass = (flag_n != flag_v);
            CC_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            CC_LE: cond_pass = flag_z | (flag_n != flag_v);
            CC_AL: cond_pass = 1'b1;
            CC_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

    // Reset forces cond_ex low so nothing presented during reset takes effect.
    assign ex          = cond_pass & instr_valid & ~reset;
    assign cond_ex     = ex;
    assign pc_src_g    = pcs & ex;
    assign mem_write_g = mem_w & ex;
    assign reg_write_g = reg_w & ~no_write & ex;

    // Flag file: N/Z and C/V groups written independently, only when executed.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 4'b0000;
        end else begin
            if (flag_w[1] && ex) begin
                flag_q[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] && ex) begin
                flag_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign flags = flag_q;

    // Debug counters: saturate at all-ones; clear wins over an increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (instr_valid) begin
            if (ex) begin
                if (exec_q != CNT_MAX) begin
                    exec_q <= exec_q + CNT_W'(1);
                end
            end else begin
                if (skip_q != CNT_MAX) begin
                    skip_q <= skip_q + CNT_W'(1);
                end
            end
        end
    end

    assign exec_count = exec_q;
    assign skip_count = skip_q;

    generate
        if (PIPE_OUT != 0) begin : g_pipe
            logic pc_src_q;
            logic reg_write_q;
            logic mem_write_q;

            // One-cycle registered enables for the pipelined datapath.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pc_src_q    <= 1'b0;
                    reg_write_q <= 1'b0;
                    mem_write_q <= 1'b0;
                end else begin
                    pc_src_q    <= pc_src_g;
                    reg_write_q <= reg_write_g;
                    mem_write_q <= mem_write_g;
                end
            end

            // A freshly asserted reset discards the enable captured the cycle before.
            assign pc_src    = pc_src_q & ~reset;
            assign reg_write = reg_write_q & ~reset;
            assign mem_write = mem_write_q & ~reset;
        end else begin : g_comb
            assign pc_src    = pc_src_g;
            assign reg_write = reg_write_g;
            assign mem_write = mem_write_g;
        end
    endgenerate

endmodule

// File: doc/cond_logic_unit.md
# cond_logic_unit

Parametrised conditional-execution unit for the ARM-style datapath. It evaluates all 16 ARM condition codes against a registered NZCV flag file, gates the PC-source, register-write and memory-write enables, and updates the N/Z and C/V flag groups under separate write enables. It also supports an optional registered-output mode for the pipelined datapath, plus saturating executed/skipped instruction counters for debug. It sits between the main decoder and the datapath write ports.

## Interface

Parameters:
- PIPE_OUT, 0 — 0: enables combinational from current cond/flags; 1: enables registered, one cycle later
- CNT_W, 16 — width of exec_count / skip_count

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- instr_valid  in  1  current instruction is real (0 = bubble/stall)
- cond  in  4  instruction condition field [31:28]
- alu_flags  in  4  {N,Z,C,V} from ALU for current instruction
- flag_w  in  2  [1] write N,Z; [0] write C,V
- pcs  in  1  decoder PC-source request
- reg_w  in  1  decoder register-write request
- mem_w  in  1  decoder memory-write request
- no_write  in  1  suppress register write (CMP/CMN/TST/TEQ)
- cnt_clr  in  1  clear both counters
- pc_src  out  1  gated PC source
- reg_write  out  1  gated register write
- mem_write  out  1  gated memory write
- cond_ex  out  1  condition passed for current instruction (always combinational)
- flags  out  4  registered {N,Z,C,V}
- exec_count  out  CNT_W  valid instructions whose condition passed
- skip_count  out  CNT_W  valid instructions whose condition failed

## Operation

- Condition evaluation uses the registered flags only, never alu_flags of the same cycle.
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as never, 0.
- cond_ex = condition result & instr_valid & !reset.
- Gated enables:
  - pc_src = pcs & cond_ex
  - mem_write = mem_w & cond_ex
  - reg_write = reg_w & !no_write & cond_ex
- Flag update at edge: if flag_w[1] & cond_ex, then N,Z <= alu_flags[3:2]; if flag_w[0] & cond_ex, then C,V <= alu_flags[1:0]. The groups are independent. A failed condition leaves the flags unchanged.
- Counters at edge when instr_valid & !reset:
  - cond_ex=1: exec_count+1
  - otherwise: skip_count+1
- Both counters saturate at all-ones and never wrap.
- cnt_clr=1 sets both counters to 0 and overrides an increment in the same cycle. It does not affect the flags.
- instr_valid=0: all enables 0, no flag update, counters hold.

## Timing

- Reset (synchronous): on the clock edge with reset=1, flags = 0000, exec_count = skip_count = 0, and registered enables = 0 (PIPE_OUT=1). While reset is high, cond_ex and all enables read 0 in both modes.
- PIPE_OUT=0:
  - pc_src, reg_write and mem_write are valid in the same cycle as cond, zero latency.
  - Flag writes become visible to the next instruction's evaluation one cycle later.
- PIPE_OUT=1:
  - Enables are registered from the same-cycle gated values and appear exactly one cycle after the instruction.
  - cond_ex, the flag update and the counters keep the same timing as PIPE_OUT=0.
- Back-to-back: a flag-setting instruction in cycle t followed by a conditional instruction in cycle t+1 must see the updated flags (no bubble required).
- Reset asserted mid-stream: the registered enables from the previous cycle are discarded, so outputs are 0 the cycle after the reset edge. An instruction presented during reset is lost.

## Test plan

- Reset then AL: reset 1 cycle, then cond=1110, reg_w=1, no_write=0 → reg_write=1, flags=0000, exec_count=1 after the edge. With PIPE_OUT=1, reg_write=1 appears one cycle later.
- Flag groups: flag_w=10, alu_flags=1111, cond=AL → flags=1100. Next, flag_w=01, alu_flags=0011 → flags=1111.
- Condition sweep: for each of the 16 cond codes × all 16 flag values (preloaded via AL writes), check cond_ex against the table. Code 1111 is always 0. Checks include GE with N=1,V=1 → 1, and LT with N=1,V=0 → 1.
- Back-to-back: CMP-style op with cond=AL, flag_w=11, alu_flags=0100, no_write=1 → reg_write=0. Next cycle, EQ with mem_w=1 → mem_write=1. Then NE with pcs=1 → pc_src=0, skip_count=1, flags unchanged.
- Bubbles and counters: instr_valid=0 with pcs=1 → pc_src=0, counters unchanged.
  - With CNT_W=2, run 5 passing AL instructions → exec_count=3 (saturated).
  - cnt_clr together with a passing instruction → exec_count=0.
- Mid-run reset, PIPE_OUT=1: a passing mem_w instruction in cycle t with reset=1 in cycle t+1 → mem_write=0 at t+1 and t+2, flags=0000, counters=0.
